// File: rtl/dual_fetch_buffer.sv
// Circular buffer between fetch and dual issue: up to two pushes per cycle at tail,
// the two oldest entries presented as slot0/slot1, up to two in-order pops per cycle.

module dfb_slot #(
  parameter int XLEN = 32,
  parameter int PCW  = 32
) (
  input  logic            vld,
  input  logic [PCW-1:0]  pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [PCW-1:0]  pc,
  output logic [XLEN-1:0] instr
);
  assign pc    = vld ? pc_in    : '0;
  assign instr = vld ? instr_in : '0;
endmodule

module dual_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int PCW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  logic [PCW-1:0]           in_pc0,
  input  logic [XLEN-1:0]          in_instr0,
  input  logic [PCW-1:0]           in_pc1,
  input  logic [XLEN-1:0]          in_instr1,
  output logic                     in_ready,
  output logic                     out_valid0,
  output logic                     out_valid1,
  output logic [PCW-1:0]           out_pc0,
  output logic [XLEN-1:0]          out_instr0,
  output logic [PCW-1:0]           out_pc1,
  output logic [XLEN-1:0]          out_instr1,
  input  logic                     issue0,
  input  logic                     issue1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [1:0]      push_n, pop_n;
  logic [1:0]      slot_v;
  logic [PCW-1:0]  slot_pc    [2];
  logic [XLEN-1:0] slot_instr [2];

  // Ready only looks at registered occupancy, so a same-cycle pop never opens room.
  assign in_ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid0)
      push_n = in_valid1 ? 2'd2 : 2'd1;
  end

  // issue1 only counts behind issue0 so slots leave strictly in order.
  assign pop_n = {1'b0, issue0 && slot_v[0]} + {1'b0, issue0 && issue1 && slot_v[1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage is left unreset; only pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (push_n != 2'd0) mem[tail] <= '{pc: in_pc0, instr: in_instr0};
      if (push_n == 2'd2) mem[tail + PW'(1)] <= '{pc: in_pc1, instr: in_instr1};
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign slot_v[s] = (count > CW'(s));
    dfb_slot #(.XLEN(XLEN), .PCW(PCW)) u_slot (
      .vld      (slot_v[s]),
      .pc_in    (mem[head + PW'(s)].pc),
      .instr_in (mem[head + PW'(s)].instr),
      .pc       (slot_pc[s]),
      .instr    (slot_instr[s])
    );
  end

  assign out_valid0 = slot_v[0];
  assign out_valid1 = slot_v[1];
  assign out_pc0    = slot_pc[0];
  assign out_instr0 = slot_instr[0];
  assign out_pc1    = slot_pc[1];
  assign out_instr1 = slot_instr[1];
endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Directed plus random stimulus for dual_fetch_buffer; a PC queue models buffer contents.

module tb_dual_fetch_buffer;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid0, in_valid1, issue0, issue1;
  logic [31:0] in_pc0, in_instr0, in_pc1, in_instr1;
  logic        in_ready, out_valid0, out_valid1;
  logic [31:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];
  logic [31:0] next_pc = 32'h1000;

  dual_fetch_buffer #(.DEPTH(4), .XLEN(32), .PCW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_pc0(in_pc0), .in_instr0(in_instr0), .in_pc1(in_pc1), .in_instr1(in_instr1),
    .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_instr0(out_instr0), .out_pc1(out_pc1), .out_instr1(out_instr1),
    .issue0(issue0), .issue1(issue1), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = sb.size();
    chk("count",      32'(count),      32'(n));
    chk("in_ready",   32'(in_ready),   32'(n <= 2));
    chk("out_valid0", 32'(out_valid0), 32'(n >= 1));
    chk("out_valid1", 32'(out_valid1), 32'(n >= 2));
    chk("out_pc0",    out_pc0,    (n >= 1) ? sb[0] : 32'h0);
    chk("out_instr0", out_instr0, (n >= 1) ? ins_of(sb[0]) : 32'h0);
    chk("out_pc1",    out_pc1,    (n >= 2) ? sb[1] : 32'h0);
    chk("out_instr1", out_instr1, (n >= 2) ? ins_of(sb[1]) : 32'h0);
  endtask

  // Drive one cycle; scoreboard is updated from the pre-edge model state.
  task automatic step(input bit v0, input bit v1, input logic [31:0] p0, input logic [31:0] p1,
                      input bit i0, input bit i1, input bit fl);
    int  n = sb.size();
    bit  rdy = (n <= 2);
    int  pops = ((i0 && n >= 1) ? 1 : 0) + ((i0 && i1 && n >= 2) ? 1 : 0);
    in_valid0 = v0; in_valid1 = v1;
    in_pc0 = p0; in_instr0 = ins_of(p0);
    in_pc1 = p1; in_instr1 = ins_of(p1);
    issue0 = i0; issue1 = i1; flush = fl;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      for (int k = 0; k < pops; k++) void'(sb.pop_front());
      if (rdy && v0) begin
        sb.push_back(p0);
        if (v1) sb.push_back(p1);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue0 = 1'b0; issue1 = 1'b0;
    in_valid0 = 1'b1; in_valid1 = 1'b1;
    in_pc0 = 32'h999; in_instr0 = 32'h1; in_pc1 = 32'h99d; in_instr1 = 32'h2;
    issue0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    step(1, 1, 32'h100, 32'h104, 0, 0, 0);   // first pair, visible next cycle
    step(1, 1, 32'h108, 32'h10C, 0, 0, 0);   // fills to 4
    step(1, 1, 32'h110, 32'h114, 0, 0, 0);   // dropped while full
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);   // count 3
    step(1, 1, 32'h200, 32'h204, 1, 0, 0);   // partial issue, push dropped
    chk("partial_pc0", out_pc0, 32'h108);
    step(0, 0, 32'h0,   32'h0,   0, 1, 0);   // issue1 alone pops nothing
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);   // dual pop to empty
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);   // issue on empty is a no-op

    for (int c = 0; c < 40; c++) begin
      bit v0 = 1'($urandom_range(0, 1));
      bit v1 = 1'($urandom_range(0, 1));
      bit i0 = 1'($urandom_range(0, 1));
      bit i1 = 1'($urandom_range(0, 1));
      logic [31:0] p0 = next_pc;
      logic [31:0] p1 = next_pc + 32'd4;
      bit took = (sb.size() <= 2) && v0;
      step(v0, v1, p0, p1, i0, i1, 0);
      if (took) next_pc = next_pc + (v1 ? 32'd8 : 32'd4);
    end

    step(0, 0, 32'h0,   32'h0,   0, 0, 1);   // flush to empty
    step(1, 1, 32'h300, 32'h304, 0, 0, 0);
    step(1, 0, 32'h308, 32'h0,   0, 0, 0);   // count 3
    step(1, 1, 32'h400, 32'h404, 1, 1, 1);   // flush beats push and pop
    step(1, 1, 32'h500, 32'h504, 0, 0, 0);   // buffer usable after flush
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
